// File: rtl/stage_5_writeback.sv
// MEM/WB pipeline register, writeback select, 32-entry register file and retired-op counter.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through on both read ports.
module stage_5_writeback #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Valid_Mem,
    input  logic              Reg_Write_Mem,
    input  logic              Is_Load_Mem,
    input  logic              Is_Jump_Mem,
    input  logic [REG_AW-1:0] Rd_Mem,
    input  logic [XLEN-1:0]   Alu_Out_Mem,
    input  logic [XLEN-1:0]   Loaded_Data_MEM,
    input  logic [XLEN-1:0]   Pc_Plus4_Mem,
    input  logic [REG_AW-1:0] Rs1_Addr,
    input  logic [REG_AW-1:0] Rs2_Addr,
    output logic [XLEN-1:0]   Rs1_Data,
    output logic [XLEN-1:0]   Rs2_Data,
    output logic              Wb_Valid,
    output logic              Wb_We,
    output logic [REG_AW-1:0] Wb_Rd,
    output logic [XLEN-1:0]   Wb_Data,
    output logic [31:0]       Retired_Count
);

    logic              valid_q;
    logic              reg_write_q;
    logic              is_load_q;
    logic              is_jump_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   alu_out_q;
    logic [XLEN-1:0]   load_data_q;
    logic [XLEN-1:0]   pc_plus4_q;

    logic [XLEN-1:0]   regs_q [NREG];
    logic [31:0]       retired_q;
    logic [31:0]       retired_d;

    logic              commit;
    logic [XLEN-1:0]   wb_data;
    logic              wb_we;

    // MEM/WB register; a flushed op keeps its fields but loses its valid bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
            is_jump_q   <= 1'b0;
            rd_q        <= '0;
            alu_out_q   <= '0;
            load_data_q <= '0;
            pc_plus4_q  <= '0;
        end else if (!Stall) begin
            valid_q     <= Valid_Mem & ~Flush;
            reg_write_q <= Reg_Write_Mem;
            is_load_q   <= Is_Load_Mem;
            is_jump_q   <= Is_Jump_Mem;
            rd_q        <= Rd_Mem;
            alu_out_q   <= Alu_Out_Mem;
            load_data_q <= Loaded_Data_MEM;
            pc_plus4_q  <= Pc_Plus4_Mem;
        end
    end

    // Jump has priority over load when both flags are set.
    always_comb begin
        wb_data = alu_out_q;
        if (is_jump_q) begin
            wb_data = pc_plus4_q;
        end else if (is_load_q) begin
            wb_data = load_data_q;
        end
    end

    assign commit = valid_q & ~Stall & ~Reset;
    assign wb_we  = commit & reg_write_q & (rd_q != '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[rd_q] <= wb_data;
        end
    end

    always_comb begin
        Rs1_Data = (Rs1_Addr == '0) ? '0 : regs_q[Rs1_Addr];
        Rs2_Data = (Rs2_Addr == '0) ? '0 : regs_q[Rs2_Addr];
`ifdef REGFILE_BYPASS_EN
        // wb_we already excludes x0, so no extra zero check is needed here.
        if (wb_we && (Rs1_Addr == rd_q)) begin
            Rs1_Data = wb_data;
        end
        if (wb_we && (Rs2_Addr == rd_q)) begin
            Rs2_Data = wb_data;
        end
`endif
    end

    always_comb begin
        retired_d = retired_q;
        if (commit) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign Wb_Valid      = valid_q;
    assign Wb_We         = wb_we;
    assign Wb_Rd         = rd_q;
    assign Wb_Data       = wb_data;
    assign Retired_Count = retired_q;

endmodule
